dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the processor load/store path (port "cpu") and a DMA/debug loader (port "dma").
- Sits between those masters and data_memory.
- Issues at most one memory access per cycle and tracks outstanding reads over a configurable read latency.
- Arbitrates by round-robin, or by CPU priority with a DMA starvation guard.

Parameters:
- AW, 16, address width (matches datapath word width)
- DW, 16, data width
- RD_LAT, 1, cycles from mem_read assertion to valid mem_rdata (1..4)
- PRIO_MODE, 0, 0 = round-robin, 1 = CPU fixed priority with starvation guard
- STARVE_LIMIT, 4, PRIO_MODE=1 only: number of consecutive cycles a pending DMA request may be denied before it is forced (1..15)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- cpu_req  input  1  CPU access request; hold with fields stable until cpu_gnt
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  AW  word address
- cpu_wdata  input  DW  write data
- cpu_gnt  output  1  combinational; access accepted this cycle
- cpu_rvalid  output  1  read data for CPU valid this cycle
- dma_req  input  1  DMA request, same rules as cpu_req
- dma_we  input  1  DMA write enable
- dma_addr  input  AW  DMA address
- dma_wdata  input  DW  DMA write data
- dma_gnt  output  1  combinational grant
- dma_rvalid  output  1  read data for DMA valid this cycle
- rdata  output  DW  shared read data; equals mem_rdata, meaningful only with an rvalid
- mem_addr  output  AW  to data_memory address
- mem_wdata  output  DW  to data_memory write_data
- mem_read  output  1  to data_memory memRead
- mem_write  output  1  to data_memory memWrite
- mem_rdata  input  DW  from data_memory read_data

Behaviour:
- Reset values (asynchronous):
  - gnt, rvalid, mem_read and mem_write are all 0.
  - Outstanding-read pipeline cleared.
  - last_owner = DMA, so CPU wins the first round-robin tie.
  - starve_cnt = 0.
- Free condition: no read is outstanding, or the outstanding read returns this cycle (cycle t+RD_LAT). With RD_LAT=1, back-to-back grants are possible every cycle.
- Grant, when free:
  - Only one requester: that requester is granted.
  - Both requesting, PRIO_MODE=0: grant the requester not equal to last_owner.
  - Both requesting, PRIO_MODE=1: grant CPU unless starve_cnt == STARVE_LIMIT, in which case grant DMA.
- Not free: both gnt = 0. Requesters keep req high; no request is lost.
- Grant cycle t:
  - mem_addr/mem_wdata are muxed from the winner.
  - mem_write = winner_we; mem_read = ~winner_we.
  - last_owner <= winner.
  - When no grant is issued, mem_read = mem_write = 0 and mem_addr/mem_wdata hold the CPU fields.
- Write completes in cycle t; no rvalid is produced.
- Read granted at t: the owner's rvalid is high exactly in cycle t+RD_LAT, a registered shift of RD_LAT stages carrying the owner tag. rdata = mem_rdata combinationally.
- starve_cnt (PRIO_MODE=1):
  - Increments (saturating at STARVE_LIMIT) on each cycle with dma_req=1 and dma_gnt=0, including non-free cycles.
  - Clears on dma_gnt or when dma_req=0.
  - With PRIO_MODE=0 it is held at 0.
- Request withdrawn before grant: allowed; no side effects.
- rst during an outstanding read: the read is discarded, its rvalid never asserts, and arbitration restarts from the reset state.
- Exactly one of cpu_gnt/dma_gnt, or neither, per cycle. mem_read and mem_write are never both 1.

Test Plan:
- Reset, then cpu_req write addr 0x0010 data 0xBEEF with dma idle -> cpu_gnt=1 and mem_write=1 in the same cycle; next cycle CPU read of 0x0010 -> cpu_rvalid=1 one cycle later with rdata=0xBEEF.
- PRIO_MODE=0, both ports issuing continuous reads with RD_LAT=1 -> grants alternate CPU, DMA, CPU, DMA; each rvalid arrives 1 cycle after its grant and is routed to the correct port.
- RD_LAT=3, CPU read granted at cycle 10 with DMA requesting -> dma_gnt=0 in cycles 11–12 and dma_gnt=1 in cycle 13, the same cycle cpu_rvalid=1.
- PRIO_MODE=1, STARVE_LIMIT=4, cpu_req held high and dma_req held high from cycle 0 -> CPU granted in cycles 0–3, DMA granted in cycle 4, CPU in cycles 5–8, DMA in cycle 9.
- DMA read granted, RD_LAT=2, rst pulsed in the following cycle -> dma_rvalid never asserts; after reset release with both requesting, CPU is granted first.
- Random mix of reads and writes on both ports against a memory model -> every rvalid matches the model and the one-hot grant / no-simultaneous read+write invariants hold.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-ported data memory between the processor load/store
//   path (cpu) and a DMA/debug loader (dma). At most one access is issued
//   per cycle; reads are tracked through an RD_LAT-deep valid/owner pipeline
//   so that the returning data is flagged to the right requester.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request (held stable until cpu_gnt)
//   cpu_gnt                      combinational accept for the CPU
//   cpu_rvalid                   read data for the CPU is on rdata
//   dma_req/we/addr/wdata        DMA request (held stable until dma_gnt)
//   dma_gnt                      combinational accept for the DMA
//   dma_rvalid                   read data for the DMA is on rdata
//   rdata                        shared read data (mem_rdata pass-through)
//   mem_addr/wdata/read/write    to data_memory
//   mem_rdata                    from data_memory
//
// Parameters
//   AW, DW        address / data width
//   RD_LAT        cycles from mem_read to valid mem_rdata (1..4)
//   PRIO_MODE     0 = round-robin, 1 = CPU priority with DMA starvation guard
//   STARVE_LIMIT  denied DMA cycles before the DMA is forced (1..15)
module dmem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int RD_LAT       = 1,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Saturating increment of the DMA starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= 4'(STARVE_LIMIT)) return 4'(STARVE_LIMIT);
    return v + 4'd1;
  endfunction

  logic [RD_LAT-1:0] vld_p;      // read in flight, index = cycles since issue - 1
  logic [RD_LAT-1:0] tag_p;      // owner of that read, 1 = DMA
  logic              last_owner;
  logic [3:0]        starve_cnt;

  logic busy;
  logic free;
  logic pick_dma;
  logic gnt_any;
  logic win_we;

  // A read in its final stage returns this cycle, so it does not block a
  // new grant; any earlier stage does.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) busy = busy | vld_p[i];
  end

  assign free = ~rst & ~busy;

  // pick_dma can only be 1 while dma_req is high.
  always_comb begin
    pick_dma = 1'b0;
    if (dma_req && !cpu_req) begin
      pick_dma = 1'b1;
    end else if (dma_req && cpu_req) begin
      if (PRIO_MODE == 0) pick_dma = (last_owner == OWN_CPU);
      else                pick_dma = (starve_cnt == 4'(STARVE_LIMIT));
    end
  end

  assign dma_gnt   = free & dma_req & pick_dma;
  assign cpu_gnt   = free & cpu_req & ~pick_dma;
  assign gnt_any   = cpu_gnt | dma_gnt;
  assign win_we    = pick_dma ? dma_we : cpu_we;

  // Idle cycles present the CPU fields on the memory bus.
  assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  assign mem_write = gnt_any & win_we;
  assign mem_read  = gnt_any & ~win_we;

  assign rdata      = mem_rdata;
  assign cpu_rvalid = vld_p[RD_LAT-1] & ~tag_p[RD_LAT-1];
  assign dma_rvalid = vld_p[RD_LAT-1] &  tag_p[RD_LAT-1];

  // Issue -> return pipeline (control part, reset)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p      <= '0;
      last_owner <= OWN_DMA;
      starve_cnt <= '0;
    end else begin
      vld_p[0] <= mem_read;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      if (gnt_any) last_owner <= dma_gnt ? OWN_DMA : OWN_CPU;
      if (PRIO_MODE == 0 || !dma_req || dma_gnt) starve_cnt <= '0;
      else                                       starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Issue -> return pipeline (owner tag, qualified by vld_p)
  always_ff @(posedge clk) begin
    tag_p[0] <= dma_gnt;
    for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Two arbiter instances share one clock:
//     g[0]: PRIO_MODE=0 (round-robin), RD_LAT=1
//     g[1]: PRIO_MODE=1, STARVE_LIMIT=4, RD_LAT=3
//   Each instance has a memory stub, a driver, a reference model that
//   pushes per-cycle expectations and expected read returns into queues,
//   and a monitor that pops and compares on the falling edge.
module tb_dmem_arbiter;

  typedef struct {
    logic        cg;
    logic        dg;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cyc_rec_t;

  typedef struct {
    int          due;
    logic        port_dma;
    logic [15:0] data;
  } rd_rec_t;

  logic clk;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   done_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input int inst, input string name,
                       input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s cycle %0d: got 0x%04h, expected 0x%04h",
               inst, name, cyc, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int LAT  = (k == 0) ? 1 : 3;
    localparam int PRIO = k;
    localparam int LIM  = 4;

    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic        mem_read, mem_write;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(
      .AW(16), .DW(16), .RD_LAT(LAT), .PRIO_MODE(PRIO), .STARVE_LIMIT(LIM)
    ) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    // Memory stub: 16 words, read data appears LAT cycles after the read.
    logic [15:0] mem_arr [16];
    logic [15:0] rd_pipe [LAT];
    logic [15:0] cap;
    assign mem_rdata = rd_pipe[LAT-1];

    initial begin
      for (int i = 0; i < 16; i++) mem_arr[i] = 16'hA500 + 16'(i);
      for (int i = 0; i < LAT; i++) rd_pipe[i] = 16'h0;
      forever begin
        @(negedge clk);
        cap = mem_arr[mem_addr[3:0]];
        if (mem_write) mem_arr[mem_addr[3:0]] = mem_wdata;
        @(posedge clk);
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = cap;
      end
    end

    // Reference model: busy until the cycle a read is due back.
    cyc_rec_t    cq[$];
    rd_rec_t     rq[$];
    logic [15:0] ref_mem [16];
    int          m_ret;
    bit          m_last_dma;
    int          m_starve;
    logic        g_c, g_d;

    initial begin
      logic        we;
      logic [15:0] a, d;
      cyc_rec_t    e;
      for (int i = 0; i < 16; i++) ref_mem[i] = 16'hA500 + 16'(i);
      m_ret = 0; m_last_dma = 1'b1; m_starve = 0; g_c = 1'b0; g_d = 1'b0;
      forever begin
        @(posedge clk);
        #2;
        g_c = 1'b0; g_d = 1'b0; we = 1'b0;
        if (rst) begin
          m_ret = 0; m_last_dma = 1'b1; m_starve = 0;
          rq.delete();
        end else begin
          if (cyc >= m_ret) begin
            if (cpu_req && dma_req) begin
              if (PRIO == 0) g_d = !m_last_dma;
              else           g_d = (m_starve >= LIM);
              g_c = !g_d;
            end else begin
              g_c = cpu_req;
              g_d = dma_req;
            end
          end
          if (g_c || g_d) begin
            we = g_d ? dma_we : cpu_we;
            a  = g_d ? dma_addr : cpu_addr;
            d  = g_d ? dma_wdata : cpu_wdata;
            if (we) ref_mem[a[3:0]] = d;
            else begin
              rq.push_back('{cyc + LAT, g_d, ref_mem[a[3:0]]});
              m_ret = cyc + LAT;
            end
            m_last_dma = g_d;
          end
          if (PRIO == 1 && dma_req && !g_d) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
          else                              m_starve = 0;
        end
        e.cg    = g_c;
        e.dg    = g_d;
        e.rd    = (g_c || g_d) && !we;
        e.wr    = (g_c || g_d) && we;
        e.addr  = g_d ? dma_addr : cpu_addr;
        e.wdata = g_d ? dma_wdata : cpu_wdata;
        cq.push_back(e);
      end
    end

    // Monitor
    initial begin
      cyc_rec_t e;
      rd_rec_t  r;
      forever begin
        @(negedge clk);
        if (cq.size() > 0) begin
          e = cq.pop_front();
          check(k, "cpu_gnt",   16'(cpu_gnt),   16'(e.cg));
          check(k, "dma_gnt",   16'(dma_gnt),   16'(e.dg));
          check(k, "mem_read",  16'(mem_read),  16'(e.rd));
          check(k, "mem_write", 16'(mem_write), 16'(e.wr));
          check(k, "mem_addr",  mem_addr,       e.addr);
          check(k, "mem_wdata", mem_wdata,      e.wdata);
        end
        check(k, "gnt_onehot", 16'(cpu_gnt & dma_gnt),    16'h0);
        check(k, "rd_wr_excl", 16'(mem_read & mem_write), 16'h0);
        if (cpu_rvalid || dma_rvalid) begin
          if (rq.size() == 0) begin
            check(k, "rvalid_unexpected", 16'({dma_rvalid, cpu_rvalid}), 16'h0);
          end else if (rq[0].due != cyc) begin
            check(k, "rvalid_cycle", 16'(cyc), 16'(rq[0].due));
          end else begin
            r = rq.pop_front();
            check(k, "rvalid_port", 16'({dma_rvalid, cpu_rvalid}),
                  r.port_dma ? 16'h2 : 16'h1);
            check(k, "rdata", rdata, r.data);
          end
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
          r = rq.pop_front();
          check(k, "rvalid_missing", 16'(cpu_rvalid | dma_rvalid), 16'h1);
        end
      end
    end

    // Driver
    initial begin
      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      if (k == 0) begin
        // CPU write 0xBEEF to 0x0010, then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
        @(posedge clk); #1;
        cpu_we = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        // Continuous reads from both ports
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0007;
        repeat (8) begin @(posedge clk); #1; end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
      end else begin
        // Both ports writing continuously: starvation guard cadence
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0001; cpu_wdata = 16'h1111;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0002; dma_wdata = 16'h2222;
        repeat (12) begin @(posedge clk); #1; end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        // CPU read with DMA waiting behind the 3-cycle read latency
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0002;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        dma_req = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
      end

      // Reset during an outstanding DMA read, then a tie after reset
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0005;
      @(posedge clk); #1;
      dma_req = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0006;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0008;
      @(posedge clk); #1;
      cpu_req = 1'b0; dma_req = 1'b0;
      repeat (LAT + 2) begin @(posedge clk); #1; end

      // Random mix of reads and writes, requests held until granted
      for (int n = 0; n < 400; n++) begin
        if (!cpu_req || g_c) begin
          cpu_req   = ($urandom_range(0, 3) != 0);
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = 16'($urandom_range(0, 15));
          cpu_wdata = 16'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          cpu_req = 1'b0;
        end
        if (!dma_req || g_d) begin
          dma_req   = ($urandom_range(0, 2) != 0);
          dma_we    = 1'($urandom_range(0, 1));
          dma_addr  = 16'($urandom_range(0, 15));
          dma_wdata = 16'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          dma_req = 1'b0;
        end
        @(posedge clk); #1;
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      repeat (LAT + 3) begin @(posedge clk); #1; end
      done_cnt++;
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    done_cnt = 0;
    for (int t = 0; t < 20000 && done_cnt < 2; t++) @(posedge clk);
    if (done_cnt < 2) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: drivers done %0d, expected 2", done_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
